// File: rtl/die_pkg.sv
// Shared die constants: 7-segment face encodings, face type, reader FSM states.
package die_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned FACE_W  = 3;
  localparam int unsigned STB_W   = 8;
  localparam int unsigned N_FACES = 6;

  typedef logic [SEG_W-1:0]  seg_t;
  typedef logic [FACE_W-1:0] face_t;

  // Segment patterns, bit0 = a ... bit6 = g, active high
  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_FACE1 = 7'h06;
  localparam seg_t SEG_FACE2 = 7'h5B;
  localparam seg_t SEG_FACE3 = 7'h4F;
  localparam seg_t SEG_FACE4 = 7'h66;
  localparam seg_t SEG_FACE5 = 7'h6D;
  localparam seg_t SEG_FACE6 = 7'h7D;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HOLD,
    ST_REARM
  } rd_state_e;

endpackage

// File: rtl/die_face_reader_if.sv
// Result handshake bundle: producer drives valid/face, consumer drives ready.
interface die_face_reader_if;

  logic              result_valid;
  die_pkg::face_t    result_face;
  logic              result_ready;

  modport master (
    output result_valid,
    output result_face,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  result_face,
    output result_ready
  );

endinterface

// File: rtl/die_seg_decode.sv
// Combinational 7-segment pattern classifier: face value, legal face, blank, illegal.
module die_seg_decode
  import die_pkg::*;
(
  input  seg_t  seg_i,
  output face_t face_c_o,
  output logic  is_face_c_o,
  output logic  is_blank_c_o,
  output logic  is_illegal_c_o
);

  // Map each legal pattern to its face; everything else non-blank is illegal
  always_comb begin
    face_c_o       = '0;
    is_face_c_o    = 1'b1;
    is_blank_c_o   = 1'b0;
    is_illegal_c_o = 1'b0;
    case (seg_i)
      SEG_FACE1: face_c_o = 3'd1;
      SEG_FACE2: face_c_o = 3'd2;
      SEG_FACE3: face_c_o = 3'd3;
      SEG_FACE4: face_c_o = 3'd4;
      SEG_FACE5: face_c_o = 3'd5;
      SEG_FACE6: face_c_o = 3'd6;
      SEG_BLANK: begin
        is_face_c_o  = 1'b0;
        is_blank_c_o = 1'b1;
      end
      default: begin
        is_face_c_o    = 1'b0;
        is_illegal_c_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/die_face_reader.sv
// Die display receiver: samples seg_in, filters bounce/animation, reports one
// settled face per roll over a valid/ready handshake.
// Optional per-face tallies enabled by defining DIE_TALLY_EN.
module die_face_reader
  import die_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  seg_t               seg_in,
  die_face_reader_if.master  res,
  output logic               err,
  input  logic               err_clr,
  input  face_t              tally_sel,
  output logic [CNT_W-1:0]   tally_out,
  input  logic               tally_clr
);

  seg_t             seg_q;
  rd_state_e        state_q, state_d;
  seg_t             pat_q, pat_d;
  logic [STB_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  face_t            face_q, face_d;
  logic             err_q, err_d;

  face_t dec_face;
  logic  dec_is_face, dec_is_blank, dec_is_illegal;
  logic  hs;

  assign hs = valid_q & res.result_ready;

  die_seg_decode u_dec (
    .seg_i          (seg_q),
    .face_c_o       (dec_face),
    .is_face_c_o    (dec_is_face),
    .is_blank_c_o   (dec_is_blank),
    .is_illegal_c_o (dec_is_illegal)
  );

  // State register plus sampled segments and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= SEG_BLANK;
      state_q <= ST_WAIT;
      pat_q   <= SEG_BLANK;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      face_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      seg_q   <= seg_in;
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      face_q  <= face_d;
      err_q   <= err_d;
    end
  end

  // Next-state: stability filter on the latched pattern, hold until accepted
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (dec_is_face) begin
          pat_d   = seg_q;
          cnt_d   = 8'd1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (dec_is_illegal || dec_is_blank) begin
          state_d = ST_WAIT;
        end else if (seg_q == pat_q) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(STABLE_CYCLES - 1)) state_d = ST_HOLD;
        end else begin
          pat_d = seg_q;
          cnt_d = 8'd1;
        end
      end
      ST_HOLD: begin
        if (hs) state_d = ST_REARM;
      end
      ST_REARM: begin
        if (seg_q != pat_q) state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Output next-values: valid tracks HOLD, face captured on HOLD entry, sticky err
  always_comb begin
    valid_d = (state_d == ST_HOLD);
    face_d  = face_q;
    err_d   = err_q;
    if (state_q != ST_HOLD && state_d == ST_HOLD) face_d = dec_face;
    if (dec_is_illegal && state_q != ST_HOLD) err_d = 1'b1;
    else if (err_clr)                          err_d = 1'b0;
  end

  assign res.result_valid = valid_q;
  assign res.result_face  = face_q;
  assign err              = err_q;

`ifdef DIE_TALLY_EN
  logic [CNT_W-1:0] tally_q [N_FACES];

  // Per-face saturating roll counters; clear beats a same-edge increment
  always_ff @(posedge clk) begin
    if (rst || tally_clr) begin
      for (int i = 0; i < int'(N_FACES); i++) tally_q[i] <= '0;
    end else if (hs) begin
      for (int i = 0; i < int'(N_FACES); i++) begin
        if (face_q == FACE_W'(i + 1) && tally_q[i] != '1) tally_q[i] <= tally_q[i] + 1'b1;
      end
    end
  end

  // Combinational tally read; selects 0 and 7 read zero
  always_comb begin
    tally_out = '0;
    for (int i = 0; i < int'(N_FACES); i++) begin
      if (tally_sel == FACE_W'(i + 1)) tally_out = tally_q[i];
    end
  end
`else
  wire unused_tally = &{1'b0, tally_sel, tally_clr};
  assign tally_out = '0;
`endif

endmodule
